// File: rtl/dec_nto2n_seq.sv
// N-to-2^N registered decoder with an optional self-running one-hot scan.
// Define DEC_SCAN_EN to build the IDLE/SCAN/DONE scan engine; otherwise the block is direct decode only.
module dec_nto2n_seq #(
  parameter  int SEL_W = 3,
  parameter  int HOLD  = 1,
  localparam int OUT_W = 2**SEL_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [SEL_W-1:0] in,
  input  logic             mode,
  input  logic             start,
  output logic [OUT_W-1:0] Y,
  output logic [SEL_W-1:0] idx,
  output logic             busy,
  output logic             done
);

  logic [OUT_W-1:0] y_q, y_d;
  logic [OUT_W-1:0] dec_val;

  assign dec_val = en ? (OUT_W'(1) << in) : '0;
  assign Y       = y_q;

`ifdef DEC_SCAN_EN
  localparam int HC_W = (HOLD > 1) ? $clog2(HOLD) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  idx_q, idx_d;
  logic [HC_W-1:0]   hold_q, hold_d;

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (start && mode) begin
          state_d = SCAN;
          idx_d   = '0;
          hold_d  = '0;
          y_d     = OUT_W'(1);
        end else begin
          y_d = dec_val;
        end
      end
      SCAN: begin
        // Step advances only after the current index has been held HOLD cycles.
        if (hold_q == HC_W'(HOLD - 1)) begin
          hold_d = '0;
          if (idx_q == SEL_W'(OUT_W - 1)) begin
            state_d = DONE;
            idx_d   = '0;
            y_d     = '0;
          end else begin
            idx_d = idx_q + 1'b1;
            y_d   = OUT_W'(1) << idx_d;
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        y_d     = '0;
        idx_d   = '0;
        hold_d  = '0;
      end
      default: begin
        state_d = IDLE;
        y_d     = '0;
        idx_d   = '0;
        hold_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      y_q     <= '0;
      idx_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
    end
  end

  // idx_q is cleared on every exit from SCAN, so it already reads 0 outside a scan.
  assign idx  = idx_q;
  assign busy = (state_q == SCAN);
  assign done = (state_q == DONE);
`else
  logic unused_scan_inputs;

  assign unused_scan_inputs = ^{mode, start};
  assign y_d  = dec_val;
  assign idx  = '0;
  assign busy = 1'b0;
  assign done = 1'b0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) y_q <= '0;
    else       y_q <= y_d;
  end
`endif

endmodule

// File: tb/tb_dec_nto2n_seq.sv
// Randomized bench for dec_nto2n_seq: two instances (HOLD=1 and HOLD=3) sharing direct-mode inputs.
// Scan scenarios are exercised when DEC_SCAN_EN is defined; the direct-only build is checked otherwise.
module tb_dec_nto2n_seq;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0, mode = 1'b0, start1 = 1'b0, start3 = 1'b0;
  logic [2:0] in = '0;
  logic [7:0] y1, y3;
  logic [2:0] idx1, idx3;
  logic       busy1, busy3, done1, done3;
  int         vectors = 0;
  int         miscompares = 0;

  always #5 clk = ~clk;

  dec_nto2n_seq #(.SEL_W(3), .HOLD(1)) u_h1 (
    .clk(clk), .reset(reset), .en(en), .in(in), .mode(mode), .start(start1),
    .Y(y1), .idx(idx1), .busy(busy1), .done(done1));

  dec_nto2n_seq #(.SEL_W(3), .HOLD(3)) u_h3 (
    .clk(clk), .reset(reset), .en(en), .in(in), .mode(mode), .start(start3),
    .Y(y3), .idx(idx3), .busy(busy3), .done(done3));

  // Reference: direct decode value for a given enable/select.
  function automatic logic [7:0] dec(input logic e, input logic [2:0] s);
    return e ? (8'h01 << s) : 8'h00;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] e;
    reset = 1'b1;
    #1;
    vectors++;
    if ({y1, idx1, busy1, done1} !== 13'd0) begin
      miscompares++;
      $display("FAIL reset_h1 got Y=%h idx=%0d busy=%b done=%b want all zero", y1, idx1, busy1, done1);
    end
    vectors++;
    if ({y3, idx3, busy3, done3} !== 13'd0) begin
      miscompares++;
      $display("FAIL reset_h3 got Y=%h idx=%0d busy=%b done=%b want all zero", y3, idx3, busy3, done3);
    end
    step();
    reset = 1'b0;
    en = 1'b1; in = 3'd6; e = dec(1'b1, 3'd6);
    step();
    vectors++;
    if (y1 !== e) begin
      miscompares++;
      $display("FAIL pre_async_reset got Y=%h want %h", y1, e);
    end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if ({y1, y3} !== 16'h0) begin
      miscompares++;
      $display("FAIL async_reset got Y1=%h Y3=%h want 00 00", y1, y3);
    end
    reset = 1'b0;
  endtask

  task automatic test_direct();
    logic [7:0] e;
    en = 1'b1; in = 3'b101; mode = 1'b0;
    step();
    vectors++;
    if (y1 !== 8'b0010_0000 || y3 !== 8'b0010_0000) begin
      miscompares++;
      $display("FAIL direct_101 got Y1=%h Y3=%h want 20", y1, y3);
    end
    en = 1'b0;
    step();
    vectors++;
    if (y1 !== 8'h00 || y3 !== 8'h00) begin
      miscompares++;
      $display("FAIL direct_en0 got Y1=%h Y3=%h want 00", y1, y3);
    end
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in = 3'(i);
      step();
      vectors++;
      if (y1 !== (8'h01 << i) || $countones(y1) != 1) begin
        miscompares++;
        $display("FAIL sweep_%0d got Y=%h want %h", i, y1, 8'h01 << i);
      end
    end
    for (int i = 0; i < 40; i++) begin
      en   = 1'($urandom);
      in   = 3'($urandom);
      mode = 1'($urandom);
      // start with mode=0 must still decode; start with mode=1 would launch a scan
      start1 = mode ? 1'b0 : 1'($urandom);
      start3 = mode ? 1'b0 : 1'($urandom);
      e = dec(en, in);
      step();
      vectors++;
      if ({y1, idx1, busy1, done1} !== {e, 5'd0} || {y3, idx3, busy3, done3} !== {e, 5'd0}) begin
        miscompares++;
        $display("FAIL rand_direct_%0d got Y1=%h Y3=%h b=%b%b d=%b%b want Y=%h idle", i, y1, y3,
                 busy1, busy3, done1, done3, e);
      end
    end
    start1 = 1'b0; start3 = 1'b0; mode = 1'b0;
  endtask

`ifdef DEC_SCAN_EN
  task automatic test_scan(input int which);
    int         h;
    logic [7:0] oe, e;
    logic [12:0] obs, oth;
    h = (which != 0) ? 3 : 1;
    en = 1'($urandom); in = 3'($urandom); mode = 1'b1;
    if (which != 0) start3 = 1'b1; else start1 = 1'b1;
    oe = dec(en, in);
    step();
    start1 = 1'b0; start3 = 1'b0;
    for (int k = 0; k < 8 * h; k++) begin
      obs = (which != 0) ? {y3, idx3, busy3, done3} : {y1, idx1, busy1, done1};
      oth = (which != 0) ? {y1, idx1, busy1, done1} : {y3, idx3, busy3, done3};
      vectors++;
      if (obs !== {8'h01 << (k / h), 3'(k / h), 2'b10}) begin
        miscompares++;
        $display("FAIL scan_h%0d_cyc%0d got Y/idx/busy/done=%h want Y=%h idx=%0d busy", h, k, obs,
                 8'h01 << (k / h), k / h);
      end
      vectors++;
      if (oth !== {oe, 5'd0}) begin
        miscompares++;
        $display("FAIL scan_h%0d_other_cyc%0d got %h want Y=%h idle", h, k, oth, oe);
      end
      en = 1'($urandom); in = 3'($urandom); mode = 1'($urandom);
      // stray start pulses during the scan must be ignored
      if (which != 0) start3 = 1'($urandom); else start1 = 1'($urandom);
      oe = dec(en, in);
      step();
    end
    obs = (which != 0) ? {y3, idx3, busy3, done3} : {y1, idx1, busy1, done1};
    vectors++;
    if (obs !== 13'b1) begin
      miscompares++;
      $display("FAIL done_h%0d got Y/idx/busy/done=%h want done pulse only", h, obs);
    end
    // start during DONE is also ignored
    mode = 1'b1;
    if (which != 0) start3 = 1'b1; else start1 = 1'b1;
    step();
    start1 = 1'b0; start3 = 1'b0;
    obs = (which != 0) ? {y3, idx3, busy3, done3} : {y1, idx1, busy1, done1};
    vectors++;
    if (obs !== 13'd0) begin
      miscompares++;
      $display("FAIL post_done_h%0d got %h want idle zero", h, obs);
    end
    en = 1'b1; in = 3'($urandom); e = dec(en, in);
    step();
    obs = (which != 0) ? {y3, idx3, busy3, done3} : {y1, idx1, busy1, done1};
    vectors++;
    if (obs !== {e, 5'd0}) begin
      miscompares++;
      $display("FAIL resume_h%0d got %h want Y=%h idle", h, obs, e);
    end
    mode = 1'b0;
  endtask

  task automatic test_reset_midscan();
    logic [7:0] e;
    en = 1'b0; mode = 1'b1; start1 = 1'b1;
    step();
    start1 = 1'b0;
    repeat (4) step();
    vectors++;
    if (idx1 !== 3'd4 || y1 !== 8'h10) begin
      miscompares++;
      $display("FAIL midscan_pos got idx=%0d Y=%h want idx=4 Y=10", idx1, y1);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if ({y1, idx1, busy1, done1} !== 13'd0) begin
      miscompares++;
      $display("FAIL midscan_reset got Y=%h idx=%0d busy=%b done=%b want all zero", y1, idx1, busy1, done1);
    end
    step();
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      en = 1'($urandom); in = 3'($urandom); mode = 1'($urandom); start1 = 1'b0;
      e = dec(en, in);
      step();
      vectors++;
      if ({y1, idx1, busy1, done1} !== {e, 5'd0}) begin
        miscompares++;
        $display("FAIL post_reset_%0d got Y=%h busy=%b done=%b want Y=%h idle", i, y1, busy1, done1, e);
      end
    end
    mode = 1'b0;
  endtask
`else
  task automatic test_no_scan();
    logic [7:0] e;
    start1 = 1'b1; start3 = 1'b1; mode = 1'b1; en = 1'b1; in = 3'd2;
    step();
    vectors++;
    if ({y1, idx1, busy1, done1} !== {8'h04, 5'd0} || {y3, idx3, busy3, done3} !== {8'h04, 5'd0}) begin
      miscompares++;
      $display("FAIL no_scan got Y1=%h Y3=%h busy=%b%b done=%b%b want Y=04 idle", y1, y3, busy1, busy3,
               done1, done3);
    end
    for (int i = 0; i < 20; i++) begin
      start1 = 1'($urandom); start3 = 1'($urandom); mode = 1'($urandom);
      en = 1'($urandom); in = 3'($urandom);
      e = dec(en, in);
      step();
      vectors++;
      if ({y1, idx1, busy1, done1} !== {e, 5'd0} || {y3, idx3, busy3, done3} !== {e, 5'd0}) begin
        miscompares++;
        $display("FAIL no_scan_rand_%0d got Y1=%h Y3=%h want %h idle", i, y1, y3, e);
      end
    end
    start1 = 1'b0; start3 = 1'b0; mode = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_direct();
`ifdef DEC_SCAN_EN
    test_scan(0);
    test_scan(1);
    test_reset_midscan();
`else
    test_no_scan();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
